// File: rtl/ahb2wb_burst_if.sv
// Bus bundle for the AHB-Lite to Wishbone B3 burst bridge: AHB address/data
// phase signals on one side, Wishbone master signals on the other.
interface ahb2wb_burst_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    // AHB-Lite side
    logic                hsel;
    logic [1:0]          htrans;
    logic                hwrite;
    logic [2:0]          hsize;
    logic [2:0]          hburst;
    logic [AWIDTH-1:0]   haddr;
    logic [DWIDTH-1:0]   hwdata;
    logic [DWIDTH-1:0]   hrdata;
    logic                hready;
    logic [1:0]          hresp;
    // Wishbone side
    logic [AWIDTH-1:0]   adr_o;
    logic [DWIDTH-1:0]   dat_o;
    logic [DWIDTH-1:0]   dat_i;
    logic [DWIDTH/8-1:0] sel_o;
    logic                we_o;
    logic                cyc_o;
    logic                stb_o;
    logic [2:0]          cti_o;
    logic [1:0]          bte_o;
    logic                ack_i;
    logic                err_i;

    // Bridge view: AHB slave towards the fabric, Wishbone master towards the peripheral.
    modport slave (
        input  hsel, htrans, hwrite, hsize, hburst, haddr, hwdata, dat_i, ack_i, err_i,
        output hrdata, hready, hresp, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o
    );

    // Environment view: the AHB master plus the Wishbone slave.
    modport master (
        output hsel, htrans, hwrite, hsize, hburst, haddr, hwdata, dat_i, ack_i, err_i,
        input  hrdata, hready, hresp, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o
    );
endinterface

// File: rtl/ahb2wb_burst.sv
// AHB-Lite slave to Wishbone B3 master bridge with burst tagging (cti/bte),
// byte-lane selects from hsize, err_i mapped to a two-cycle AHB ERROR and an
// ack watchdog. One transfer is outstanding at a time.
module ahb2wb_burst #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ahb2wb_burst_if.slave bus
);
    localparam int NLANE = DWIDTH / 8;
    localparam int LW    = $clog2(NLANE);
    localparam int WDW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_ERROR    = 2'b01;
    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INCR      = 3'b010;
    localparam logic [2:0] CTI_END       = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_DONE, S_HOLD, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] adr_q, adr_d;
    logic [NLANE-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic [2:0]        cti_q, cti_d;
    logic [1:0]        bte_q, bte_d;
    logic [DWIDTH-1:0] hrdata_q, hrdata_d;
    logic              hready_q, hready_d;
    logic [1:0]        hresp_q, hresp_d;
    logic [4:0]        beats_q, beats_d;
    logic [WDW-1:0]    wd_q, wd_d;

    logic       accept;
    logic       oversize;
    logic       fixed_burst;
    logic [4:0] beats_nxt;

    // Lanes [lo +: 2^size] with lo aligned down to the transfer size, little-endian.
    function automatic logic [NLANE-1:0] lane_mask(input logic [LW-1:0] lo, input logic [2:0] size);
        logic [NLANE-1:0] m;
        int span;
        int base;
        span = 1 << int'(size);
        base = int'(lo) & ~(span - 1);
        m    = '0;
        for (int i = 0; i < NLANE; i++) begin
            m[i] = (i >= base) && (i < base + span);
        end
        return m;
    endfunction

    // Beat count of fixed-length bursts; SINGLE and INCR are open-ended (0).
    function automatic logic [4:0] burst_len(input logic [2:0] hb);
        logic [4:0] n;
        case (hb[2:1])
            2'b01:   n = 5'd4;
            2'b10:   n = 5'd8;
            2'b11:   n = 5'd16;
            default: n = 5'd0;
        endcase
        return n;
    endfunction

    assign accept      = bus.hsel && hready_q && bus.htrans[1] &&
                         (state_q inside {S_IDLE, S_DONE, S_HOLD});
    assign oversize    = (bus.hsize > 3'(LW));
    assign fixed_burst = (bus.hburst[2:1] != 2'b00);
    assign beats_nxt   = (bus.htrans == HTRANS_NONSEQ) ? burst_len(bus.hburst) : beats_q;

    // State register and all registered bus outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            cti_q    <= CTI_CLASSIC;
            bte_q    <= 2'b00;
            hrdata_q <= '0;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
            beats_q  <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            cti_q    <= cti_d;
            bte_q    <= bte_d;
            hrdata_q <= hrdata_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            beats_q  <= beats_d;
            wd_q     <= wd_d;
        end
    end

    // Next-state and next-output logic for the bridge FSM.
    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        state_d  = state_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        cti_d    = cti_q;
        bte_d    = bte_q;
        hrdata_d = hrdata_q;
        hready_d = hready_q;
        hresp_d  = hresp_q;
        beats_d  = beats_q;
        wd_d     = wd_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_HOLD: begin
                if (accept) begin
                    adr_d   = bus.haddr;
                    we_d    = bus.hwrite;
                    sel_d   = lane_mask(bus.haddr[LW-1:0], bus.hsize);
                    beats_d = beats_nxt;
                    wd_d    = '0;
                    if (!fixed_burst)         cti_d = CTI_CLASSIC;
                    else if (beats_nxt == 1)  cti_d = CTI_END;
                    else                      cti_d = CTI_INCR;
                    case (bus.hburst)
                        3'b010:  bte_d = 2'b01;
                        3'b100:  bte_d = 2'b10;
                        3'b110:  bte_d = 2'b11;
                        default: bte_d = 2'b00;
                    endcase
                    hready_d = 1'b0;
                    if (oversize) begin
                        // Too wide for the bus: answer with ERROR, never touch Wishbone.
                        state_d = S_ERR1;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        hresp_d = RESP_ERROR;
                    end else begin
                        state_d = S_ACCESS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        hresp_d = RESP_OKAY;
                    end
                end else if (state_q != S_IDLE && bus.hsel && bus.htrans == HTRANS_BUSY) begin
                    // Burst paused: keep the Wishbone cycle open without strobing.
                    state_d = S_HOLD;
                    stb_d   = 1'b0;
                end else if (state_q != S_IDLE) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end
            end
            S_ACCESS: begin
                if (bus.err_i) begin
                    state_d = S_ERR1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    hresp_d = RESP_ERROR;
                end else if (bus.ack_i) begin
                    state_d  = S_DONE;
                    stb_d    = 1'b0;
                    hready_d = 1'b1;
                    hresp_d  = RESP_OKAY;
                    hrdata_d = bus.dat_i;
                    if (beats_q != 0) beats_d = beats_q - 5'd1;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    // Slave is unresponsive: abort the cycle and report ERROR.
                    state_d = S_ERR1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    hresp_d = RESP_ERROR;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_ERR1: begin
                state_d  = S_ERR2;
                hready_d = 1'b1;
                hresp_d  = RESP_ERROR;
            end
            S_ERR2: begin
                state_d  = S_IDLE;
                hready_d = 1'b1;
                hresp_d  = RESP_OKAY;
            end
            default: begin
                state_d  = S_IDLE;
                cyc_d    = 1'b0;
                stb_d    = 1'b0;
                hready_d = 1'b1;
                hresp_d  = RESP_OKAY;
            end
        endcase
    end

    assign bus.hrdata = hrdata_q;
    assign bus.hready = hready_q;
    assign bus.hresp  = hresp_q;
    assign bus.adr_o  = adr_q;
    assign bus.dat_o  = bus.hwdata;
    assign bus.sel_o  = sel_q;
    assign bus.we_o   = we_q;
    assign bus.cyc_o  = cyc_q;
    assign bus.stb_o  = stb_q;
    assign bus.cti_o  = cti_q;
    assign bus.bte_o  = bte_q;
endmodule

// File: tb/tb_ahb2wb_burst.sv
// Directed bench for ahb2wb_burst: a Wishbone slave model records each acked
// beat, expected beats and read data are queued as stimulus is driven.
module tb_ahb2wb_burst;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] dat;
    } wb_beat_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    ahb2wb_burst_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    ahb2wb_burst #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wait_n  = 0;
    logic        never_ack = 1'b0;
    logic        give_err  = 1'b0;
    logic        fixed_en  = 1'b0;
    logic [31:0] fixed_dat = '0;
    logic        track_cyc = 1'b0;
    int          cyc_low   = 0;

    wb_beat_t    exp_wb[$];
    wb_beat_t    obs_wb[$];
    logic [31:0] exp_rd[$];

    logic [31:0] t_addr [3] = '{32'h102, 32'h101, 32'h105};
    logic [2:0]  t_size [3] = '{3'd1, 3'd1, 3'd0};
    logic [3:0]  t_sel  [3] = '{4'b1100, 4'b0011, 4'b0010};

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (track_cyc && bus.cyc_o !== 1'b1) cyc_low++;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                              input logic [2:0] sz, input logic [2:0] hb);
        bus.hsel   = 1'b1;
        bus.htrans = tr;
        bus.haddr  = a;
        bus.hwrite = wr;
        bus.hsize  = sz;
        bus.hburst = hb;
    endtask

    task automatic idle_phase();
        bus.hsel   = 1'b0;
        bus.htrans = T_IDLE;
    endtask

    task automatic wait_ready(inout int lat);
        int n;
        n = 0;
        do begin
            tick();
            lat++;
            n++;
        end while (bus.hready !== 1'b1 && n < 40);
        check("hready_rise", {79'b0, bus.hready}, 80'd1);
    endtask

    task automatic exp_beat(input logic [31:0] a, input logic [3:0] s, input logic w,
                            input logic [2:0] c, input logic [1:0] b, input logic [31:0] d);
        wb_beat_t e;
        e = '{adr: a, sel: s, we: w, cti: c, bte: b, dat: d};
        exp_wb.push_back(e);
    endtask

    task automatic compare_wb(input string tag);
        check({tag, "_nbeats"}, 80'(obs_wb.size()), 80'(exp_wb.size()));
        while (obs_wb.size() > 0 && exp_wb.size() > 0) begin
            check({tag, "_beat"}, 80'(obs_wb.pop_front()), 80'(exp_wb.pop_front()));
        end
        obs_wb.delete();
        exp_wb.delete();
    endtask

    task automatic check_rd(input string tag);
        logic [31:0] e;
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hx;
        check({tag, "_hrdata"}, 80'(bus.hrdata), 80'(e));
        check({tag, "_hresp"}, 80'(bus.hresp), 80'd0);
    endtask

    // Wishbone slave model: ack (or err+ack) after wait_n strobe cycles.
    initial begin
        int       wcnt;
        wb_beat_t o;
        wcnt = 0;
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            if (bus.stb_o === 1'b1 && !never_ack && wcnt == wait_n) begin
                bus.ack_i = 1'b1;
                bus.err_i = give_err;
                bus.dat_i = fixed_en ? fixed_dat : rd_model(bus.adr_o);
                o = '{adr: bus.adr_o, sel: bus.sel_o, we: bus.we_o, cti: bus.cti_o,
                      bte: bus.bte_o, dat: bus.we_o ? bus.dat_o : 32'h0};
                obs_wb.push_back(o);
                wcnt = 0;
            end else begin
                bus.ack_i = 1'b0;
                bus.err_i = 1'b0;
                wcnt = (bus.stb_o === 1'b1) ? wcnt + 1 : 0;
            end
        end
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int n;
        logic [31:0] a;

        idle_phase();
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd2;
        bus.hburst = 3'd0;
        bus.haddr  = '0;
        bus.hwdata = '0;

        repeat (3) tick();
        check("rst_ahb", {bus.hready, bus.hresp, bus.hrdata}, {1'b1, 2'b00, 32'h0});
        check("rst_wb", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.sel_o, bus.cti_o, bus.bte_o}, 80'd0);
        rst_i = 1'b0;
        tick();

        // Single word write, two wait states
        wait_n = 2;
        exp_beat(32'h100, 4'hF, 1'b1, 3'b000, 2'b00, 32'hDEADBEEF);
        addr_phase(T_NONSEQ, 32'h100, 1'b1, 3'd2, 3'd0);
        tick();
        lat = 1;
        bus.hwdata = 32'hDEADBEEF;
        idle_phase();
        check("wr_access", {bus.cyc_o, bus.stb_o, bus.hready}, 80'b110);
        wait_ready(lat);
        check("wr_latency", 80'(lat), 80'd4);
        check("wr_done", {bus.hresp, bus.cyc_o, bus.stb_o}, {2'b00, 1'b1, 1'b0});
        tick();
        check("wr_cyc_drop", {bus.cyc_o, bus.hready}, 80'b01);
        compare_wb("wr");

        // Byte read at 0x203, zero-wait
        wait_n = 0;
        fixed_en = 1'b1;
        fixed_dat = 32'h11223344;
        exp_beat(32'h203, 4'b1000, 1'b0, 3'b000, 2'b00, 32'h0);
        exp_rd.push_back(32'h11223344);
        addr_phase(T_NONSEQ, 32'h203, 1'b0, 3'd0, 3'd0);
        tick();
        lat = 1;
        idle_phase();
        wait_ready(lat);
        check("byte_latency", 80'(lat), 80'd2);
        check_rd("byte");
        tick();
        fixed_en = 1'b0;
        compare_wb("byte");

        // Lane select table: halfword, misaligned halfword, byte
        for (int i = 0; i < 3; i++) begin
            exp_beat(t_addr[i], t_sel[i], 1'b1, 3'b000, 2'b00, 32'hA5A5_0000 + 32'(i));
            addr_phase(T_NONSEQ, t_addr[i], 1'b1, t_size[i], 3'd0);
            tick();
            bus.hwdata = 32'hA5A5_0000 + 32'(i);
            idle_phase();
            lat = 1;
            wait_ready(lat);
            check("sel_hresp", 80'(bus.hresp), 80'd0);
            tick();
        end
        compare_wb("sel");

        // INCR4 read at 0x40, zero-wait, cyc_o must stay high
        cyc_low = 0;
        track_cyc = 1'b1;
        lat = 0;
        addr_phase(T_NONSEQ, 32'h40, 1'b0, 3'd2, 3'd3);
        exp_beat(32'h40, 4'hF, 1'b0, 3'b010, 2'b00, 32'h0);
        exp_rd.push_back(rd_model(32'h40));
        for (int i = 0; i < 4; i++) begin
            tick();
            lat++;
            if (i < 3) begin
                a = 32'h40 + 32'(4 * (i + 1));
                addr_phase(T_SEQ, a, 1'b0, 3'd2, 3'd3);
                exp_beat(a, 4'hF, 1'b0, (i == 2) ? 3'b111 : 3'b010, 2'b00, 32'h0);
                exp_rd.push_back(rd_model(a));
            end else begin
                idle_phase();
            end
            wait_ready(lat);
            check_rd("incr4");
        end
        track_cyc = 1'b0;
        check("incr4_cycles", 80'(lat), 80'd8);
        check("incr4_cyc_low", 80'(cyc_low), 80'd0);
        tick();
        compare_wb("incr4");

        // WRAP4 read at 0x38 with a BUSY after the second beat
        addr_phase(T_NONSEQ, 32'h38, 1'b0, 3'd2, 3'd2);
        exp_beat(32'h38, 4'hF, 1'b0, 3'b010, 2'b01, 32'h0);
        exp_rd.push_back(rd_model(32'h38));
        tick();
        addr_phase(T_SEQ, 32'h3C, 1'b0, 3'd2, 3'd2);
        exp_beat(32'h3C, 4'hF, 1'b0, 3'b010, 2'b01, 32'h0);
        exp_rd.push_back(rd_model(32'h3C));
        lat = 1;
        wait_ready(lat);
        check_rd("wrap4_b0");
        tick();
        addr_phase(T_BUSY, 32'h30, 1'b0, 3'd2, 3'd2);
        wait_ready(lat);
        check_rd("wrap4_b1");
        tick();
        check("wrap4_hold", {bus.cyc_o, bus.stb_o, bus.hready, bus.hresp}, 80'b10100);
        addr_phase(T_SEQ, 32'h30, 1'b0, 3'd2, 3'd2);
        exp_beat(32'h30, 4'hF, 1'b0, 3'b010, 2'b01, 32'h0);
        exp_rd.push_back(rd_model(32'h30));
        tick();
        addr_phase(T_SEQ, 32'h34, 1'b0, 3'd2, 3'd2);
        exp_beat(32'h34, 4'hF, 1'b0, 3'b111, 2'b01, 32'h0);
        exp_rd.push_back(rd_model(32'h34));
        wait_ready(lat);
        check_rd("wrap4_b2");
        tick();
        idle_phase();
        wait_ready(lat);
        check_rd("wrap4_b3");
        tick();
        compare_wb("wrap4");

        // err_i together with ack_i; a transfer offered in ERR2 is ignored
        give_err = 1'b1;
        exp_beat(32'h80, 4'hF, 1'b0, 3'b000, 2'b00, 32'h0);
        addr_phase(T_NONSEQ, 32'h80, 1'b0, 3'd2, 3'd0);
        tick();
        idle_phase();
        tick();
        check("err1", {bus.hready, bus.hresp, bus.cyc_o, bus.stb_o}, 80'b00100);
        tick();
        check("err2", {bus.hready, bus.hresp, bus.cyc_o, bus.stb_o}, 80'b10100);
        addr_phase(T_NONSEQ, 32'h90, 1'b0, 3'd2, 3'd0);
        tick();
        check("err_ignored", {bus.hready, bus.hresp, bus.cyc_o, bus.stb_o}, 80'b10000);
        idle_phase();
        give_err = 1'b0;
        tick();
        compare_wb("err");

        // hsize wider than the bus: ERROR with no Wishbone cycle
        addr_phase(T_NONSEQ, 32'h84, 1'b0, 3'd3, 3'd0);
        tick();
        idle_phase();
        check("oversize_err1", {bus.hready, bus.hresp, bus.cyc_o, bus.stb_o}, 80'b00100);
        tick();
        check("oversize_err2", {bus.hready, bus.hresp, bus.cyc_o, bus.stb_o}, 80'b10100);
        tick();
        check("oversize_idle", {bus.hready, bus.hresp}, 80'b100);
        compare_wb("oversize");

        // Watchdog expiry with a silent slave
        never_ack = 1'b1;
        addr_phase(T_NONSEQ, 32'h300, 1'b0, 3'd2, 3'd0);
        tick();
        idle_phase();
        n = 0;
        while (bus.stb_o === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("wd_stb_cycles", 80'(n), 80'd8);
        check("wd_err1", {bus.hready, bus.hresp, bus.cyc_o}, 80'b0010);
        tick();
        check("wd_err2", {bus.hready, bus.hresp}, 80'b101);
        tick();
        never_ack = 1'b0;

        // ack_i in the expiry cycle wins over the watchdog
        wait_n = 7;
        exp_beat(32'h304, 4'hF, 1'b0, 3'b000, 2'b00, 32'h0);
        exp_rd.push_back(rd_model(32'h304));
        addr_phase(T_NONSEQ, 32'h304, 1'b0, 3'd2, 3'd0);
        tick();
        lat = 1;
        idle_phase();
        wait_ready(lat);
        check("wd_ack_latency", 80'(lat), 80'd9);
        check_rd("wd_ack");
        tick();
        compare_wb("wd_ack");
        wait_n = 0;

        // Reset in the middle of an access
        never_ack = 1'b1;
        addr_phase(T_NONSEQ, 32'h400, 1'b1, 3'd2, 3'd5);
        tick();
        idle_phase();
        tick();
        check("mid_access", {bus.cyc_o, bus.stb_o, bus.hready}, 80'b110);
        rst_i = 1'b1;
        tick();
        check("rst_mid_ahb", {bus.hready, bus.hresp, bus.hrdata}, {1'b1, 2'b00, 32'h0});
        check("rst_mid_wb", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.sel_o, bus.cti_o, bus.bte_o}, 80'd0);
        rst_i = 1'b0;
        never_ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
